muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the RV32M subset, sitting beside the EX-stage ALU and controlled by its own sequencer FSM. EX issues an M-extension R-type instruction here instead of to the ALU, and the unit stalls the pipeline until the result is ready. It then presents the result for one cycle, in time for EX to capture it into EX/MEM.

## Interface
- XLEN, 32, operand and result width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request. EX asserts it when opcode is R-type and func7 = 7'b0000001.
- func3  in  3  operation select: 000 MUL, 011 MULHU, 101 DIVU, 111 REMU.
- a  in  XLEN  rs1 operand. Sampled on the accepting edge.
- b  in  XLEN  rs2 operand. Sampled on the accepting edge.
- flush  in  1  abort from the hazard unit (branch taken or trap).
- busy  out  1  an operation is in progress.
- stall  out  1  freezes PC, IF/ID and ID/EX; equals (state==IDLE & start & ~flush) | busy.
- done  out  1  one-cycle pulse: result is valid.
- result  out  XLEN  registered result. Holds its value until the next done.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & ~flush latches a, b and func3, and clears the iteration counter.
  - func3 000/011 goes to MUL.
  - func3 101/111 with b != 0 goes to DIV.
  - func3 101/111 with b == 0 goes to DONE.
  - Any other func3 goes to DONE with result 0.
- MUL: unsigned shift-add over a 2*XLEN product register, one multiplier bit per cycle, XLEN cycles. The counter reaching XLEN-1 moves to DONE.
  - MUL returns product[XLEN-1:0].
  - MULHU returns product[2*XLEN-1:XLEN].
- DIV: restoring division, one quotient bit per cycle, XLEN cycles. Partial remainder is XLEN+1 bits wide so the subtract borrow is visible. The counter reaching XLEN-1 moves to DONE.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (RISC-V rule, no exception):
  - DIVU returns all ones (0xFFFFFFFF).
  - REMU returns a.
- DONE: result is written on entry; done = 1 for exactly this cycle; the next state is always IDLE.
- start in any state other than IDLE is ignored. The pipeline is stalled then, so this only happens in error.
- flush has priority over everything except rst.
  - In MUL or DIV, flush returns the FSM to IDLE on the next edge: no done, result unchanged.
  - flush in DONE has no effect; done still pulses.
  - flush in IDLE blocks acceptance of start.
- Arithmetic is unsigned throughout. All adders are XLEN+1 bits. No overflow flag.

## Timing
- Reset values: state IDLE, busy 0, stall 0, done 0, result 0, counter 0.
- Accept edge T: start sampled high in IDLE.
- During the cycle before edge T, stall is already 1 (combinational from start), so ID/EX holds the instruction.
- MUL/DIV latency:
  - busy = 1 in cycles T+1 … T+XLEN (32 cycles).
  - done = 1 and result valid in cycle T+XLEN+1.
  - stall = 0 in the done cycle, so EX/MEM captures result at the end of it.
- Divide by zero or unsupported func3: DONE in cycle T+1 (latency 1); busy never asserted.
- Back-to-back: a new start can be accepted in the IDLE cycle immediately after DONE. Throughput is one operation per XLEN+2 cycles.
- rst mid-operation: on the next edge, all state returns to reset values. No done; result cleared.
- busy and done are never high in the same cycle.

## Test plan
- MUL a=7, b=6, start one cycle → stall high before the accept edge; busy high for 32 cycles; done at T+33 with result 0x0000002A.
- MULHU a=b=0xFFFFFFFF → result 0xFFFFFFFE. Then MUL with the same operands → result 0x00000001; second start accepted in the IDLE cycle after the first done.
- DIVU a=100, b=7 → result 14. REMU a=100, b=7 → result 2. REMU a=0x80000000, b=0xFFFFFFFF → result 0x80000000.
- Divide by zero: DIVU a=5, b=0 → done at T+1, result 0xFFFFFFFF, busy never high. REMU a=5, b=0 → result 5.
- flush at busy cycle 10 of a DIVU → busy 0 next cycle; no done for 40 cycles; result keeps its previous value. A fresh MUL 3×3 started afterwards returns 9.
- rst asserted at busy cycle 5 of a MUL → all outputs 0 on the next cycle. func3=001 with start → done at T+1, result 0, busy never high.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide beside the EX-stage ALU.
// Shift-add multiply and restoring divide, one bit per cycle; stalls the
// pipeline while busy and pulses done for one cycle with a registered result.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);

   localparam logic [2:0] F_MUL   = 3'b000;
   localparam logic [2:0] F_MULHU = 3'b011;
   localparam logic [2:0] F_DIVU  = 3'b101;
   localparam logic [2:0] F_REMU  = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [2:0]          op_q;
   logic [XLEN-1:0]     opnd_q;     // multiplicand (MUL) or divisor (DIV)
   logic [2*XLEN-1:0]   prod_q;     // {partial product, remaining multiplier bits}
   logic [XLEN-1:0]     rem_q;      // partial remainder (always < divisor)
   logic [XLEN-1:0]     quo_q;      // dividend bits shifting out, quotient bits in
   logic                busy_q;
   logic                done_q;
   logic [XLEN-1:0]     result_q;

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   prod_d;
   logic [XLEN:0]       rem_sh;
   logic [XLEN:0]       div_diff;
   logic [XLEN-1:0]     rem_d;
   logic [XLEN-1:0]     quo_d;
   logic                last_iter;

   // One iteration of the shift-add multiplier and the restoring divider.
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
      prod_d    = {mul_sum, prod_q[XLEN-1:1]};
      rem_sh    = {rem_q, quo_q[XLEN-1]};
      // rem_sh < 2*divisor, so bit XLEN of the difference is the borrow.
      div_diff  = rem_sh - {1'b0, opnd_q};
      rem_d     = div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0];
      quo_d     = {quo_q[XLEN-2:0], ~div_diff[XLEN]};
      last_iter = (cnt_q == CW'(XLEN-1));
   end

   // Sequencer FSM with datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start && !flush) begin
                  op_q  <= func3;
                  cnt_q <= '0;
                  if (func3 == F_MUL || func3 == F_MULHU) begin
                     opnd_q  <= a;
                     prod_q  <= {XLEN'(0), b};
                     busy_q  <= 1'b1;
                     state_q <= S_MUL;
                  end else if (func3 == F_DIVU || func3 == F_REMU) begin
                     if (b != '0) begin
                        opnd_q  <= b;
                        quo_q   <= a;
                        rem_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_DIV;
                     end else begin
                        // Divide by zero: quotient all ones, remainder is the dividend.
                        result_q <= (func3 == F_DIVU) ? '1 : a;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                     end
                  end else begin
                     result_q <= '0;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  prod_q <= prod_d;
                  cnt_q  <= cnt_q + CW'(1);
                  if (last_iter) begin
                     result_q <= (op_q == F_MULHU) ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end
               end
            end
            S_DIV: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q + CW'(1);
                  if (last_iter) begin
                     result_q <= (op_q == F_REMU) ? rem_d : quo_d;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   // Stall asserts combinationally in the request cycle so ID/EX holds the instruction.
   assign stall  = ((state_q == S_IDLE) && start && !flush) || busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors, expected results queued at issue
// and checked by an independent monitor on each done pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  func3;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] last_res = '0;

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .func3  (func3),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         check("busy_and_done_overlap", 32'(busy), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            check(name_q.pop_front(), result, exp_q.pop_front());
         end
      end
   end

   // Issue one operation and verify stall, busy duration and done latency.
   task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic [31:0] ex, input int lat);
      int nb;
      int got;
      nb  = 0;
      got = 0;
      @(negedge clk);
      start = 1'b1;
      func3 = f;
      a     = op_a;
      b     = op_b;
      #1 check({nm, "_stall_pre"}, 32'(stall), 32'd1);
      exp_q.push_back(ex);
      name_q.push_back(nm);
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin
            got = k;
            check({nm, "_stall_done"}, 32'(stall), 32'd0);
            break;
         end
      end
      check({nm, "_latency"}, 32'(got), 32'(lat));
      check({nm, "_busy_cycles"}, 32'(nb), 32'(lat - 1));
      last_res = ex;
   endtask

   initial begin
      int nb;
      rst   = 1'b1;
      start = 1'b0;
      func3 = 3'b000;
      a     = '0;
      b     = '0;
      flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy",   32'(busy),  32'd0);
      check("reset_done",   32'(done),  32'd0);
      check("reset_stall",  32'(stall), 32'd0);
      check("reset_result", result,     32'd0);
      rst = 1'b0;

      issue("mul_7x6",       3'b000, 32'd7,          32'd6,          32'h0000002A, 33);
      issue("mulhu_ff",      3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33);
      issue("mul_ff_b2b",    3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 33);
      issue("mulhu_2p16",    3'b011, 32'h00010000,   32'h00010000,   32'h00000001, 33);
      issue("divu_100_7",    3'b101, 32'd100,        32'd7,          32'd14,       33);
      issue("remu_100_7",    3'b111, 32'd100,        32'd7,          32'd2,        33);
      issue("remu_big",      3'b111, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 33);
      issue("divu_big",      3'b101, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 33);
      issue("remu_wide",     3'b111, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE, 33);
      issue("divu_by_1",     3'b101, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 33);
      issue("divu_by_zero",  3'b101, 32'd5,          32'd0,          32'hFFFFFFFF, 1);
      issue("remu_by_zero",  3'b111, 32'd5,          32'd0,          32'd5,        1);

      // Flush a DIVU at its 10th busy cycle: no done, result untouched.
      @(negedge clk);
      start = 1'b1;
      func3 = 3'b101;
      a     = 32'd1000;
      b     = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      nb = 0;
      for (int k = 0; k < 50 && nb < 10; k++) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check("flush_reached_busy10", 32'(nb), 32'd10);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_next", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      check("flush_result_kept", result, last_res);
      issue("mul_3x3_post_flush", 3'b000, 32'd3, 32'd3, 32'd9, 33);

      // Reset at the 5th busy cycle of a MUL.
      @(negedge clk);
      start = 1'b1;
      func3 = 3'b000;
      a     = 32'd11;
      b     = 32'd13;
      @(posedge clk);
      #1 start = 1'b0;
      nb = 0;
      for (int k = 0; k < 50 && nb < 5; k++) begin
         @(negedge clk);
         if (busy) nb++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_busy",   32'(busy),  32'd0);
      check("rst_mid_done",   32'(done),  32'd0);
      check("rst_mid_stall",  32'(stall), 32'd0);
      check("rst_mid_result", result,     32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue("unsupported_001", 3'b001, 32'd123, 32'd45, 32'd0, 1);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
